// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit
// Owns the fetch PC for a combinational word-addressed instruction ROM and
// buffers fetched words in a small prefetch FIFO. The FIFO presents {instr, pc}
// to decode with a valid/ready handshake. The unit also handles redirects
// (flush and restart) and a halt request.
//
// Optional feature: define PREFETCH_BYPASS_EN to present the ROM word directly
// to decode whenever the FIFO is empty and fetch is active. This removes the
// one-cycle fetch latency.
module instr_prefetch_unit #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = 32'hBFC00000,
    parameter int                         DEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ADDRESS_WIDTH-1:0]  mem_pc,
    input  logic [DATA_WIDTH-1:0]     mem_instr,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [DATA_WIDTH-1:0]     instr,
    output logic [ADDRESS_WIDTH-1:0]  instr_pc,
    input  logic                      redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]  redirect_pc,
    input  logic                      halt_req,
    output logic                      halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                     state, state_next;
    logic [ADDRESS_WIDTH-1:0]   fetch_pc;
    logic [CNT_W-1:0]           count;
    logic [PTR_W-1:0]           rd_ptr, wr_ptr;

    logic [DATA_WIDTH-1:0]      instr_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0]   pc_mem    [DEPTH];

    logic                       fifo_valid;
    logic                       fifo_has_room;
    logic                       pop;
    logic                       push;
    logic                       bypass_take;
    logic                       pc_advance;
    logic [ADDRESS_WIDTH-1:0]   redirect_target;

    // The ROM is word addressed. The byte-offset bits of a redirect target
    // carry no information.
    logic                       redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};

    assign mem_pc        = fetch_pc;
    assign halted        = (state == ST_HALTED);
    assign fifo_valid    = (count != '0);
    assign fifo_has_room = (count < DEPTH_CNT);

    // Handshake decode. A redirect suppresses both sides of the FIFO so the
    // flush is clean. In that cycle, instr_ready from decode is ignored.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        pop         = 1'b0;
        push        = 1'b0;
        bypass_take = 1'b0;
        if (!redirect_valid) begin
            pop  = fifo_valid & instr_ready;
            push = (state == ST_FETCH) & (fifo_has_room | pop) & ~halt_req;
`ifdef PREFETCH_BYPASS_EN
            // An empty FIFO with fetch active shows the ROM word directly.
            // If decode takes it, the word is never written into the FIFO.
            bypass_take = ~fifo_valid & (state == ST_FETCH) & instr_ready;
            push        = push & ~bypass_take;
`endif
        end
        pc_advance = push | bypass_take;
    end

    // Head presentation. The outputs are zero whenever nothing valid is offered.
    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (fifo_valid) begin
            instr_valid = 1'b1;
            instr       = instr_mem[rd_ptr];
            instr_pc    = pc_mem[rd_ptr];
        end
`ifdef PREFETCH_BYPASS_EN
        else if ((state == ST_FETCH) && !redirect_valid) begin
            instr_valid = 1'b1;
            instr       = mem_instr;
            instr_pc    = fetch_pc;
        end
`endif
    end

    // FSM next state. A redirect always wins and restarts fetch. Otherwise a
    // halt request parks the unit until the next redirect.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = ST_FETCH;
        end else if ((state == ST_FETCH) && halt_req) begin
            state_next = ST_HALTED;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC. It jumps to the redirect target on a flush, advances by one
    // word on each fetch consumed, and otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (pc_advance) begin
            fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        end
    end

    // FIFO occupancy and pointers. A flush empties the FIFO in one edge.
    // The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. It captures the ROM word and its address on each push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
        if (push) begin
            instr_mem[wr_ptr] <= mem_instr;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed testbench for instr_prefetch_unit (default build, bypass disabled).
// The ROM model returns word index i for address RESET_VECTOR + 4*i.
module tb_instr_prefetch_unit;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk;
    logic        rst;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    instr_prefetch_unit #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_VECTOR  (RV),
        .DEPTH         (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_pc         (mem_pc),
        .mem_instr      (mem_instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    // Combinational ROM: ROM[i] = i
    assign mem_instr = (mem_pc - RV) >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over one edge, then release. The first push lands on the next edge.
    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        instr_ready    = ready;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        tick();

        // Check the state held under reset.
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_instr",  instr,            32'd0);
        check("rst_pc",     instr_pc,         32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_mem_pc", mem_pc,           RV);

        // Stream a contiguous sequence with decode always ready.
        do_reset(1'b1);
        check("stream_pre_valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("stream_valid[%0d]", k), 32'(instr_valid), 32'd1);
            check($sformatf("stream_pc[%0d]", k),    instr_pc,         RV + 32'(4 * k));
            check($sformatf("stream_instr[%0d]", k), instr,            32'(k));
        end

        // Stall decode so the FIFO fills, then drain it while it is full.
        do_reset(1'b0);
        repeat (10) tick();
        check("full_mem_pc", mem_pc,           RV + 32'h10);
        check("full_valid",  32'(instr_valid), 32'd1);
        check("full_head",   instr_pc,         RV);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_pc[%0d]", k),     instr_pc, RV + 32'(4 * k));
            check($sformatf("drain_instr[%0d]", k),  instr,    32'(k));
            check($sformatf("drain_mem_pc[%0d]", k), mem_pc,   RV + 32'h10 + 32'(4 * k));
            tick();
        end

        // Redirect mid-stream: bubble, then the new path starting at the aligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00103;
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble_valid", 32'(instr_valid), 32'd0);
        check("redir_bubble_instr", instr,            32'd0);
        check("redir_bubble_pc",    instr_pc,         32'd0);
        check("redir_mem_pc",       mem_pc,           32'hBFC00100);
        tick();
        check("redir_first_valid", 32'(instr_valid), 32'd1);
        check("redir_first_pc",    instr_pc,         32'hBFC00100);
        check("redir_first_instr", instr,            32'h40);
        tick();
        check("redir_second_pc",    instr_pc, 32'hBFC00104);
        check("redir_second_instr", instr,    32'h41);

        // Raise halt and redirect together: the redirect wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00200;
        halt_req       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        check("halt_redir_halted", 32'(halted),      32'd0);
        check("halt_redir_valid",  32'(instr_valid), 32'd0);
        check("halt_redir_mem_pc", mem_pc,           32'hBFC00200);
        tick();
        check("halt_redir_first_pc",    instr_pc, 32'hBFC00200);
        check("halt_redir_first_instr", instr,    32'h80);

        // Pulse halt with three entries buffered: the FIFO drains, then stays empty.
        do_reset(1'b0);
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_mem_pc", mem_pc,      RV + 32'hC);
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("halt_drain_valid[%0d]", k), 32'(instr_valid), 32'd1);
            check($sformatf("halt_drain_pc[%0d]", k),    instr_pc,         RV + 32'(4 * k));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("halt_idle_valid[%0d]", k),  32'(instr_valid), 32'd0);
            check($sformatf("halt_idle_mem_pc[%0d]", k), mem_pc,           RV + 32'hC);
            check($sformatf("halt_idle_halted[%0d]", k), 32'(halted),      32'd1);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC00040;
        tick();
        redirect_valid = 1'b0;
        check("resume_halted", 32'(halted),      32'd0);
        check("resume_valid0", 32'(instr_valid), 32'd0);
        check("resume_mem_pc", mem_pc,           32'hBFC00040);
        tick();
        check("resume_pc",    instr_pc, 32'hBFC00040);
        check("resume_instr", instr,    32'h10);

        // Assert reset mid-stream with three entries buffered.
        do_reset(1'b0);
        repeat (3) tick();
        check("midrst_pre_pc",     instr_pc, RV);
        check("midrst_pre_mem_pc", mem_pc,   RV + 32'hC);
        rst = 1'b1;
        #1;
        check("midrst_valid",  32'(instr_valid), 32'd0);
        check("midrst_pc",     instr_pc,         32'd0);
        check("midrst_mem_pc", mem_pc,           RV);
        tick();
        rst = 1'b0;
        check("midrst_release_valid", 32'(instr_valid), 32'd0);
        tick();
        check("midrst_restart_valid", 32'(instr_valid), 32'd1);
        check("midrst_restart_pc",    instr_pc,         RV);
        check("midrst_restart_instr", instr,            32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
